// File: rtl/enigma_frame_cipher.sv
// Enigma I frame cipher: takes one received frame from the UART
// transceiver and enciphers it one character at a time. Rotors are I/II/III
// with reflector B, the ring settings are fixed at A and there is no
// plugboard. The result goes back to the transmit side. Rotor positions are
// kept from one frame to the next.
//
// Handshake: frame_valid and load_key are single-cycle strobes and are
// sampled only while idle. A frame that arrives while busy is dropped and
// sets the sticky overrun flag. frame_send is a single-cycle strobe, and
// frame_out is valid from that cycle until the next frame_send.
//
// The FSM state is held in state_q (type state_t) so that checkers can be
// bound to it.
module enigma_frame_cipher #(
    parameter int FRAME_BYTES = 10,
    parameter int ROT_L       = 1,
    parameter int ROT_M       = 2,
    parameter int ROT_R       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*FRAME_BYTES-1:0] frame_in,
    input  logic                     frame_valid,
    input  logic [14:0]              key_pos,
    input  logic                     load_key,
    output logic [8*FRAME_BYTES-1:0] frame_out,
    output logic                     frame_send,
    output logic                     busy,
    output logic                     overrun,
    output logic [14:0]              rotor_pos
);

    localparam int FW = 8 * FRAME_BYTES;
    localparam int IW = $clog2(FRAME_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

    // Each wiring table is stored as ASCII text. Character 0 (input A) sits in the top byte.
    localparam logic [207:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] REFL_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    function automatic logic [207:0] rotor_table(input int sel);
        case (sel)
            1:       return WIRE_I;
            2:       return WIRE_II;
            default: return WIRE_III;
        endcase
    endfunction

    // Turnover letters: I=Q, II=E, III=V.
    function automatic logic [4:0] notch_of(input int sel);
        case (sel)
            1:       return 5'd16;
            2:       return 5'd4;
            default: return 5'd21;
        endcase
    endfunction

    localparam logic [207:0] TBL_L   = rotor_table(ROT_L);
    localparam logic [207:0] TBL_M   = rotor_table(ROT_M);
    localparam logic [207:0] TBL_R   = rotor_table(ROT_R);
    localparam logic [4:0]   NOTCH_M = notch_of(ROT_M);
    localparam logic [4:0]   NOTCH_R = notch_of(ROT_R);

    function automatic logic [4:0] lookup(input logic [207:0] t, input logic [4:0] x);
        logic [7:0] ch;
        ch = t[8*(25 - int'(x)) +: 8];
        return 5'(ch - 8'h41);
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] mod26(input logic [4:0] x);
        return (x > 5'd25) ? x - 5'd26 : x;
    endfunction

    function automatic logic [4:0] rotor_fwd(input logic [207:0] t, input logic [4:0] x,
                                             input logic [4:0] p);
        return sub26(lookup(t, add26(x, p)), p);
    endfunction

    // The reverse path searches the table, so no separate inverse table is needed.
    function automatic logic [4:0] rotor_inv(input logic [207:0] t, input logic [4:0] x,
                                             input logic [4:0] p);
        logic [4:0] target;
        logic [4:0] y;
        target = add26(x, p);
        y      = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (lookup(t, 5'(i)) == target) y = 5'(i);
        end
        return sub26(y, p);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_ENC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   buf_q, buf_d;
    logic [FW-1:0]   res_q, res_d;
    logic [4:0]      pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
    logic [FW-1:0]   frame_out_q, frame_out_d;
    logic            frame_send_q, frame_send_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic [7:0]      cur_byte;
    logic            cur_letter;
    logic [4:0]      enc_val;
    logic [7:0]      enc_byte;

    // Encipher the byte at the head of the frame buffer, using the current rotor positions.
    always_comb begin
        logic [4:0] c;
        cur_byte   = buf_q[FW-1 -: 8];
        cur_letter = (cur_byte >= 8'h41) && (cur_byte <= 8'h5A);
        c = 5'(cur_byte - 8'h41);
        c = rotor_fwd(TBL_R, c, pos_r_q);
        c = rotor_fwd(TBL_M, c, pos_m_q);
        c = rotor_fwd(TBL_L, c, pos_l_q);
        c = lookup(REFL_B, c);
        c = rotor_inv(TBL_L, c, pos_l_q);
        c = rotor_inv(TBL_M, c, pos_m_q);
        c = rotor_inv(TBL_R, c, pos_r_q);
        enc_val  = c;
        enc_byte = cur_letter ? (8'h41 + {3'b000, enc_val}) : cur_byte;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: each character takes a STEP cycle then an ENC cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_valid) state_d = S_STEP;
            S_STEP:  state_d = S_ENC;
            S_ENC:   state_d = (idx_q == LAST_IDX) ? S_DONE : S_STEP;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values.
    always_comb begin
        buf_d        = buf_q;
        res_d        = res_q;
        idx_d        = idx_q;
        pos_l_d      = pos_l_q;
        pos_m_d      = pos_m_q;
        pos_r_d      = pos_r_q;
        frame_out_d  = frame_out_q;
        frame_send_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        if (frame_valid && busy_q) overrun_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                // The key is loaded here and stepping starts later, so a
                // frame captured on the same edge uses the new key.
                if (load_key) begin
                    pos_l_d = mod26(key_pos[14:10]);
                    pos_m_d = mod26(key_pos[9:5]);
                    pos_r_d = mod26(key_pos[4:0]);
                end
                if (frame_valid) begin
                    buf_d  = frame_in;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_STEP: begin
                if (cur_letter) begin
                    pos_r_d = add26(pos_r_q, 5'd1);
                    // A middle rotor sitting on its notch steps again (the double step) and carries the left rotor.
                    if (pos_m_q == NOTCH_M) begin
                        pos_m_d = add26(pos_m_q, 5'd1);
                        pos_l_d = add26(pos_l_q, 5'd1);
                    end else if (pos_r_q == NOTCH_R) begin
                        pos_m_d = add26(pos_m_q, 5'd1);
                    end
                end
            end
            S_ENC: begin
                res_d = (res_q << 8) | FW'(enc_byte);
                buf_d = buf_q << 8;
                if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
            end
            S_DONE: begin
                frame_out_d  = res_q;
                frame_send_d = 1'b1;
                busy_d       = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers. Reset abandons any frame that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            buf_q        <= '0;
            res_q        <= '0;
            pos_l_q      <= 5'd0;
            pos_m_q      <= 5'd0;
            pos_r_q      <= 5'd0;
            frame_out_q  <= '0;
            frame_send_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            res_q        <= res_d;
            pos_l_q      <= pos_l_d;
            pos_m_q      <= pos_m_d;
            pos_r_q      <= pos_r_d;
            frame_out_q  <= frame_out_d;
            frame_send_q <= frame_send_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign frame_out  = frame_out_q;
    assign frame_send = frame_send_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign rotor_pos  = {pos_l_q, pos_m_q, pos_r_q};

endmodule

// File: tb/tb_enigma_frame_cipher.sv
// Bench for enigma_frame_cipher. A behavioural Enigma model, written as a
// string table with modular arithmetic, predicts every frame. Those
// predictions go through an expected queue. The directed vectors come from
// the published Enigma I results.
module tb_enigma_frame_cipher;

    localparam int NB = 10;
    localparam int FW = 8 * NB;
    localparam int RL = 1;
    localparam int RM = 2;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] frame_in;
    logic          frame_valid;
    logic [14:0]   key_pos;
    logic          load_key;
    logic [FW-1:0] frame_out;
    logic          frame_send;
    logic          busy;
    logic          overrun;
    logic [14:0]   rotor_pos;

    int            n_vec = 0;
    int            n_err = 0;
    logic [FW-1:0] exp_q[$];
    logic [14:0]   pos_hist[$];
    logic [14:0]   m_hist[$];
    logic [FW-1:0] last_out;
    int            mp[3];
    string         s_l, s_m, s_r, s_ref;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    enigma_frame_cipher #(.FRAME_BYTES(NB), .ROT_L(RL), .ROT_M(RM), .ROT_R(RR)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .key_pos    (key_pos),
        .load_key   (load_key),
        .frame_out  (frame_out),
        .frame_send (frame_send),
        .busy       (busy),
        .overrun    (overrun),
        .rotor_pos  (rotor_pos)
    );

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic string rotor_str(input int n);
        if (n == 1) return "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        if (n == 2) return "AJDKSIRUXBLHWTMCQGZNPYFVOE";
        return "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    endfunction

    function automatic int wv(input string s, input int i);
        return int'(s[i]) - 65;
    endfunction

    function automatic int notch(input int n);
        string notches;
        notches = "QEV";
        return int'(notches[n-1]) - 65;
    endfunction

    function automatic int fwd(input string s, input int x, input int p);
        return (wv(s, (x + p) % 26) - p + 26) % 26;
    endfunction

    function automatic int inv(input string s, input int x, input int p);
        int t;
        t = (x + p) % 26;
        for (int i = 0; i < 26; i++) if (wv(s, i) == t) return (i - p + 26) % 26;
        return 0;
    endfunction

    function automatic logic [14:0] m_packed();
        logic [4:0] a, b, c;
        a = 5'(mp[0]);
        b = 5'(mp[1]);
        c = 5'(mp[2]);
        return {a, b, c};
    endfunction

    task automatic m_key(input logic [14:0] k);
        mp[0] = int'(k[14:10]) % 26;
        mp[1] = int'(k[9:5]) % 26;
        mp[2] = int'(k[4:0]) % 26;
    endtask

    task automatic m_step();
        bit m_at, r_at;
        m_at  = (mp[1] == notch(RM));
        r_at  = (mp[2] == notch(RR));
        mp[2] = (mp[2] + 1) % 26;
        if (m_at) begin
            mp[1] = (mp[1] + 1) % 26;
            mp[0] = (mp[0] + 1) % 26;
        end else if (r_at) begin
            mp[1] = (mp[1] + 1) % 26;
        end
    endtask

    task automatic m_frame(input logic [FW-1:0] f, output logic [FW-1:0] y);
        logic [7:0] b;
        int c;
        m_hist.delete();
        y = '0;
        for (int i = 0; i < NB; i++) begin
            b = f[FW-1-8*i -: 8];
            if (b >= 8'h41 && b <= 8'h5A) begin
                m_step();
                m_hist.push_back(m_packed());
                c = int'(b) - 65;
                c = fwd(s_r, c, mp[2]);
                c = fwd(s_m, c, mp[1]);
                c = fwd(s_l, c, mp[0]);
                c = wv(s_ref, c);
                c = inv(s_l, c, mp[0]);
                c = inv(s_m, c, mp[1]);
                c = inv(s_r, c, mp[2]);
                y[FW-1-8*i -: 8] = 8'(c + 65);
            end else begin
                y[FW-1-8*i -: 8] = b;
            end
        end
    endtask

    function automatic logic [FW-1:0] rnd_frame(input int letter_pct);
        logic [FW-1:0] f;
        for (int i = 0; i < NB; i++) begin
            if (int'($urandom_range(0, 99)) < letter_pct)
                f[FW-1-8*i -: 8] = 8'(8'h41 + $urandom_range(0, 25));
            else case ($urandom_range(0, 2))
                0:       f[FW-1-8*i -: 8] = 8'(8'h30 + $urandom_range(0, 9));
                1:       f[FW-1-8*i -: 8] = 8'(8'h61 + $urandom_range(0, 25));
                default: f[FW-1-8*i -: 8] = 8'h20;
            endcase
        end
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load(input logic [14:0] k);
        @(negedge clk);
        key_pos  = k;
        load_key = 1'b1;
        @(negedge clk);
        load_key = 1'b0;
        m_key(k);
    endtask

    task automatic run_frame(input logic [FW-1:0] f, output logic [FW-1:0] got, output int lat);
        logic [14:0] last;
        @(negedge clk);
        frame_in    = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        lat  = 0;
        last = rotor_pos;
        pos_hist.delete();
        while (frame_send !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rotor_pos != last) begin
                pos_hist.push_back(rotor_pos);
                last = rotor_pos;
            end
        end
        got = frame_out;
    endtask

    task automatic do_frame(input logic [FW-1:0] f, input string tag);
        logic [FW-1:0] y, got;
        int lat;
        m_frame(f, y);
        exp_q.push_back(y);
        run_frame(f, got, lat);
        chk({tag, "_latency"}, FW'(lat), FW'(2 * NB + 1));
        chk({tag, "_data"}, got, exp_q.pop_front());
        chk({tag, "_rotor"}, FW'(rotor_pos), FW'(m_packed()));
        chk({tag, "_steps"}, FW'(pos_hist.size()), FW'(m_hist.size()));
        for (int i = 0; i < pos_hist.size() && i < m_hist.size(); i++)
            chk({tag, "_step_pos"}, FW'(pos_hist[i]), FW'(m_hist[i]));
        @(negedge clk);
        chk({tag, "_send_pulse"}, FW'(frame_send), FW'(0));
        chk({tag, "_busy_after"}, FW'(busy), FW'(0));
        last_out = got;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [FW-1:0] x, y, f2, got;
        logic [14:0]   k;
        logic [14:0]   ds_exp[4];
        int            n_send;

        s_l   = rotor_str(RL);
        s_m   = rotor_str(RM);
        s_r   = rotor_str(RR);
        s_ref = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
        mp    = '{0, 0, 0};

        rst         = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        key_pos     = '0;
        load_key    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_frame_out", frame_out, '0);
        chk("rst_frame_send", FW'(frame_send), FW'(0));
        chk("rst_busy", FW'(busy), FW'(0));
        chk("rst_overrun", FW'(overrun), FW'(0));
        chk("rst_rotor", FW'(rotor_pos), FW'(0));

        // Textbook vector: AAA key, AAAAA -> BDZGO.
        load(15'd0);
        chk("key_aaa", FW'(rotor_pos), FW'(0));
        do_frame(80'h4141414141_2020202020, "aaaaa");
        chk("aaaaa_vector", last_out, 80'h42445A474F_2020202020);
        chk("aaaaa_aaf", FW'(rotor_pos), FW'({5'd0, 5'd0, 5'd5}));

        // Double step from ADU.
        load({5'd0, 5'd3, 5'd20});
        do_frame(80'h41414141_313233343536, "dstep");
        ds_exp = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}, {5'd1, 5'd5, 5'd24}};
        chk("dstep_count", FW'(pos_hist.size()), FW'(4));
        for (int i = 0; i < 4; i++) chk("dstep_pos", FW'(pos_hist[i]), FW'(ds_exp[i]));

        // Out-of-range key fields wrap.
        load({5'd27, 5'd30, 5'd26});
        chk("key_mod26", FW'(rotor_pos), FW'({5'd1, 5'd4, 5'd0}));

        // Reciprocity and no letter enciphers to itself.
        for (int t = 0; t < 4; t++) begin
            k = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
            x = rnd_frame(90);
            load(k);
            do_frame(x, "recip_fwd");
            y = last_out;
            for (int i = 0; i < NB; i++)
                if (x[FW-1-8*i -: 8] >= 8'h41 && x[FW-1-8*i -: 8] <= 8'h5A)
                    chk("no_selfmap", FW'(y[FW-1-8*i -: 8] != x[FW-1-8*i -: 8]), FW'(1));
            load(k);
            do_frame(y, "recip_back");
            chk("reciprocal", last_out, x);
        end

        // Digits and lowercase pass through unchanged, without stepping the rotors.
        do_frame(80'h3161_4142_7a5a_2e43_4420, "mixed");
        chk("mixed_passthru", {last_out[79:72], last_out[71:64], last_out[47:40]},
            {8'h31, 8'h61, 8'h7a});

        // Random mixed frames with the rotor positions carried across.
        for (int t = 0; t < 6; t++) do_frame(rnd_frame(60), "random");

        // Overrun: a second frame 5 cycles in is dropped, and a load_key while busy is ignored.
        x  = rnd_frame(100);
        f2 = rnd_frame(100);
        m_frame(x, y);
        exp_q.push_back(y);
        @(negedge clk);
        frame_in    = x;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (4) @(negedge clk);
        frame_in    = f2;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        key_pos     = 15'h7fff;
        load_key    = 1'b1;
        @(negedge clk);
        load_key = 1'b0;
        n_send   = 0;
        got      = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_send) begin
                n_send++;
                got = frame_out;
            end
        end
        chk("ovr_sends", FW'(n_send), FW'(1));
        chk("ovr_flag", FW'(overrun), FW'(1));
        chk("ovr_data", got, exp_q.pop_front());
        chk("ovr_rotor", FW'(rotor_pos), FW'(m_packed()));

        // Reset in mid-frame abandons the frame and returns the rotors to AAA.
        @(negedge clk);
        frame_in    = rnd_frame(100);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_key(15'd0);
        n_send = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_send) n_send++;
        end
        chk("mrst_sends", FW'(n_send), FW'(0));
        chk("mrst_frame_out", frame_out, '0);
        chk("mrst_busy", FW'(busy), FW'(0));
        chk("mrst_overrun", FW'(overrun), FW'(0));
        chk("mrst_rotor", FW'(rotor_pos), FW'(0));
        do_frame(80'h4141414141_2020202020, "post_rst");
        chk("post_rst_vector", last_out, 80'h42445A474F_2020202020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enigma_frame_cipher.md
Name: enigma_frame_cipher

Overview:
- Enigma I cipher engine between the UART frame transceiver (`data`) receive and transmit sides.
- Consumes each 80-bit frame the transceiver reports (`odata`/`datavalid`) and enciphers it character by character.
- Returns the result to the transceiver's `idata`/`senddata` inputs for transmission.
- Rotor positions persist across frames, as on a real machine, until reloaded or reset.

Parameters:
- FRAME_BYTES, 10: characters per frame; frame width is 8*FRAME_BYTES.
- ROT_L, 1: left rotor selection (1=I, 2=II, 3=III).
- ROT_M, 2: middle rotor selection, same encoding.
- ROT_R, 3: right rotor selection, same encoding.
- ROT_L, ROT_M and ROT_R are distinct.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_in  in  80  received frame; wire from the transceiver's `odata`. Byte 0 = [79:72], sent first.
- frame_valid  in  1  one-cycle strobe; wire from the transceiver's `datavalid`.
- key_pos  in  15  start positions {L,M,R}, 5 bits each, 0..25 = A..Z.
- load_key  in  1  one-cycle strobe; loads key_pos into the rotors.
- frame_out  out  80  enciphered frame; wire to the transceiver's `idata`.
- frame_send  out  1  one-cycle strobe; wire to the transceiver's `senddata`.
- busy  out  1  high while a frame is being processed.
- overrun  out  1  sticky; set when a frame arrives while busy.
- rotor_pos  out  15  current {L,M,R} positions.

Behaviour:
- Reset (synchronous, rst high at posedge): frame_out=0, frame_send=0, busy=0, overrun=0, rotor_pos=0 (AAA), FSM=IDLE. An in-flight frame is abandoned; no frame_send is issued for it.
- Wiring: rotors I/II/III and reflector B, Enigma I standard tables. Ring settings fixed at A. No plugboard.
- Notches: I=Q, II=E, III=V.
- FSM states: IDLE, STEP, ENC, DONE.
- IDLE:
  - frame_valid=1 captures frame_in, sets char index=0, busy=1, then goes to STEP.
  - load_key=1 loads key_pos. If load_key and frame_valid are both high, the key loads first and the frame uses the new key.
  - Any key_pos field greater than 25 is reduced mod 26 on load.
- STEP (char i): if the byte is 0x41..0x5A, step the rotors before enciphering:
  - Right rotor always advances.
  - Middle rotor advances if right is at its notch, or if middle is at its own notch (double step).
  - Left rotor advances if middle is at its notch.
  - All positions wrap 25 -> 0.
  - Non-letter bytes: no step.
- ENC (char i):
  - Letter: c -> R -> M -> L -> reflector -> L^-1 -> M^-1 -> R^-1. Each rotor applies (wire[(x+p) mod 26] - p) mod 26 at position p. Store 0x41 + result.
  - Non-letter byte (including lowercase): stored unchanged.
  - If i = FRAME_BYTES-1, go to DONE; otherwise increment i and go to STEP.
- DONE: frame_out is updated this cycle, frame_send=1 for exactly 1 cycle, busy=0, then IDLE.
- Fixed latency: frame_valid sampled at edge k gives frame_send high in the cycle following edge k+2*FRAME_BYTES+1 (21 for 10 bytes). Independent of content.
- frame_out holds its value until the next DONE.
- Busy conditions:
  - frame_valid while busy=1: frame dropped, overrun set.
  - load_key while busy=1: ignored.
  - overrun clears only on rst.
- Letters never encipher to themselves (reflector property); a bench checker enforces this.

Test Plan:
- rst, then load_key with key_pos=AAA; frame "AAAAA" + 5 spaces (0x4141414141_2020202020) -> frame_out=0x42445A474F_2020202020 ("BDZGO     "), rotor_pos=AAF, frame_send pulse 21 cycles after frame_valid.
- Double step: key ADU; frame "AAAA" + 6 non-letters -> rotor_pos progresses ADV, AEW, BFX, BFY; final rotor_pos=BFY.
- Reciprocity: load key, encipher frame X giving Y; reload the same key and send Y -> frame_out = X. Also check no letter maps to itself.
- frame_valid pulsed again 5 cycles after the first -> second frame dropped, overrun=1, exactly one frame_send, rotor_pos unaffected by the dropped frame.
- Frame containing digits/lowercase (0x3161_...) -> those bytes unchanged, rotor_pos advances only per uppercase letter.
- rst asserted at cycle 10 of processing -> no frame_send, all outputs 0, and the next frame behaves as from AAA.
